// File: rtl/gray_counter.sv
// Up/down binary counter with registered Gray-coded copy and a one-cycle terminal-count pulse.
// All outputs are registered one clock after the controls; gray_q is built from the next binary value.
module gray_counter #(
  parameter int unsigned WIDTH   = 4,
  parameter bit          WRAP    = 1'b1,
  parameter int unsigned RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] bin_q,
  output logic [WIDTH-1:0] gray_q,
  output logic             tc
);

  localparam logic [WIDTH-1:0] RST_BIN  = RST_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);
  localparam logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] bin_d;
  logic [WIDTH-1:0] gray_d;
  logic             tc_d;
  logic [WIDTH-1:0] bin_r_q;
  logic [WIDTH-1:0] gray_r_q;
  logic             tc_r_q;

  always_comb begin
    bin_d = bin_r_q;
    tc_d  = 1'b0;
    if (clr) begin
      bin_d = RST_BIN;
    end else if (load) begin
      bin_d = load_val;
    end else if (en) begin
      if (up) begin
        if (bin_r_q == MAX_VAL) begin
          tc_d = 1'b1;
          if (WRAP) bin_d = '0;
        end else begin
          bin_d = bin_r_q + ONE;
        end
      end else begin
        if (bin_r_q == '0) begin
          tc_d = 1'b1;
          if (WRAP) bin_d = MAX_VAL;
        end else begin
          bin_d = bin_r_q - ONE;
        end
      end
    end
    // Gray taken from the next binary so both registers agree in every cycle.
    gray_d = bin_d ^ (bin_d >> 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_r_q  <= RST_BIN;
      gray_r_q <= RST_GRAY;
      tc_r_q   <= 1'b0;
    end else begin
      bin_r_q  <= bin_d;
      gray_r_q <= gray_d;
      tc_r_q   <= tc_d;
    end
  end

  assign bin_q  = bin_r_q;
  assign gray_q = gray_r_q;
  assign tc     = tc_r_q;

endmodule
